nx_ram_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the dual-port 36 Kib RAM primitive between REQUESTERS independent clients. Each client issues read or write commands over a valid/ready handshake. The arbiter registers the winning command onto the RAM port and tracks in-flight reads so each read response returns to the client that issued it. It sits between the RAM's port A and the node-local clients (instruction fetch, message handler, debug access).

---
 rtl/nx_ram_arbiter.sv | 113 +++++++++++
 tb/tb_nx_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_ram_arbiter.sv
// nx_ram_arbiter: round-robin share of one RAM port among several clients.
// Read responses are steered back to the issuing client by a latency-matched tracker.
module nx_ram_arbiter #(
   parameter int REQUESTERS    = 4,
   parameter int ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int RD_LATENCY    = 1
) (
   input  logic                              i_clk_a,
   input  logic                              i_rst_a,
   input  logic [REQUESTERS-1:0]             i_req_valid,
   output logic [REQUESTERS-1:0]             o_req_ready,
   input  logic [REQUESTERS-1:0]             i_req_write,
   input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_req_addr,
   input  logic [REQUESTERS*DATA_WIDTH-1:0]  i_req_wr_data,
   output logic [REQUESTERS-1:0]             o_rsp_valid,
   output logic [DATA_WIDTH-1:0]             o_rsp_data,
   output logic [ADDRESS_WIDTH-1:0]          o_ram_addr,
   output logic [DATA_WIDTH-1:0]             o_ram_wr_data,
   output logic                              o_ram_wr_en,
   output logic                              o_ram_en,
   input  logic [DATA_WIDTH-1:0]             i_ram_rd_data
);

   localparam int IW = $clog2(REQUESTERS);

   logic [IW-1:0] ptr;
   logic [IW-1:0] ptr_nxt;
   logic [IW-1:0] gnt;
   logic          found;
   logic [IW-1:0] iss_idx;

   logic          trk_v [RD_LATENCY];
   logic [IW-1:0] trk_i [RD_LATENCY];

   // Grant search: first valid client at or after the pointer, wrapping.
   always_comb begin
      int j;
      j           = 0;
      found       = 1'b0;
      gnt         = '0;
      o_req_ready = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         j = int'(ptr) + k;
         if (j >= REQUESTERS) j = j - REQUESTERS;
         if (!found && i_req_valid[IW'(j)]) begin
            found = 1'b1;
            gnt   = IW'(j);
         end
      end
      if (found) o_req_ready[gnt] = 1'b1;
   end

   // Pointer moves past the winner; wraps from the last client to 0.
   always_comb begin
      ptr_nxt = ptr;
      if (found) begin
         if (gnt == IW'(REQUESTERS - 1)) ptr_nxt = '0;
         else                           ptr_nxt = gnt + 1'b1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge i_clk_a or posedge i_rst_a) begin
      if (i_rst_a) ptr <= '0;
      else         ptr <= ptr_nxt;
   end

   // Issue stage: register the winning command onto the RAM port.
   always_ff @(posedge i_clk_a or posedge i_rst_a) begin
      if (i_rst_a) begin
         o_ram_en      <= 1'b0;
         o_ram_wr_en   <= 1'b0;
         o_ram_addr    <= '0;
         o_ram_wr_data <= '0;
         iss_idx       <= '0;
      end else begin
         o_ram_en    <= found;
         o_ram_wr_en <= found & i_req_write[gnt];
         if (found) begin
            o_ram_addr    <= i_req_addr[int'(gnt)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            o_ram_wr_data <= i_req_wr_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
            iss_idx       <= gnt;
         end
      end
   end

   // Response tracker: delay {is_read, client} by the RAM read latency.
   always_ff @(posedge i_clk_a or posedge i_rst_a) begin
      if (i_rst_a) begin
         for (int k = 0; k < RD_LATENCY; k++) begin
            trk_v[k] <= 1'b0;
            trk_i[k] <= '0;
         end
      end else begin
         trk_v[0] <= o_ram_en & ~o_ram_wr_en;
         trk_i[0] <= iss_idx;
         for (int k = 1; k < RD_LATENCY; k++) begin
            trk_v[k] <= trk_v[k-1];
            trk_i[k] <= trk_i[k-1];
         end
      end
   end

   // Tail of the tracker decodes into the one-hot response strobe.
   always_comb begin
      o_rsp_valid = '0;
      if (trk_v[RD_LATENCY-1]) o_rsp_valid[trk_i[RD_LATENCY-1]] = 1'b1;
   end

   assign o_rsp_data = i_ram_rd_data;

endmodule

// File: tb/tb_nx_ram_arbiter.sv
// tb_nx_ram_arbiter: directed checks on two arbiter instances sharing stimulus,
// one against a latency-1 RAM model and one against a latency-2 RAM model.
module tb_nx_ram_arbiter;

   localparam int N  = 4;
   localparam int AW = 10;
   localparam int DW = 32;

   logic              clk;
   logic              rst;
   logic [N-1:0]      valid;
   logic [N-1:0]      wr;
   logic [N*AW-1:0]   addr;
   logic [N*DW-1:0]   wdata;

   logic [N-1:0]      rdy1, rdy2, rsp1, rsp2;
   logic [DW-1:0]     rdat1, rdat2, wd1, wd2;
   logic [AW-1:0]     a1, a2;
   logic              we1, we2, en1, en2;
   logic [DW-1:0]     rd1a, rd2a, rd2b;

   logic [DW-1:0]     mem1 [1024];
   logic [DW-1:0]     mem2 [1024];

   int n_checks;
   int n_errors;

   nx_ram_arbiter #(.REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
      .i_clk_a(clk), .i_rst_a(rst), .i_req_valid(valid), .o_req_ready(rdy1),
      .i_req_write(wr), .i_req_addr(addr), .i_req_wr_data(wdata),
      .o_rsp_valid(rsp1), .o_rsp_data(rdat1), .o_ram_addr(a1), .o_ram_wr_data(wd1),
      .o_ram_wr_en(we1), .o_ram_en(en1), .i_ram_rd_data(rd1a)
   );

   nx_ram_arbiter #(.REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut2 (
      .i_clk_a(clk), .i_rst_a(rst), .i_req_valid(valid), .o_req_ready(rdy2),
      .i_req_write(wr), .i_req_addr(addr), .i_req_wr_data(wdata),
      .o_rsp_valid(rsp2), .o_rsp_data(rdat2), .o_ram_addr(a2), .o_ram_wr_data(wd2),
      .o_ram_wr_en(we2), .o_ram_en(en2), .i_ram_rd_data(rd2b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Latency-1 RAM: read-first, so a read one cycle after a write sees new data.
   always @(posedge clk) begin
      if (en1) begin
         if (we1) mem1[a1] <= wd1;
         rd1a <= mem1[a1];
      end
   end

   // Latency-2 RAM: same array behaviour plus an output register.
   always @(posedge clk) begin
      if (en2) begin
         if (we2) mem2[a2] <= wd2;
         rd2a <= mem2[a2];
      end
      rd2b <= rd2a;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr[c]              = w;
      addr[c*AW +: AW]   = a;
      wdata[c*DW +: DW]  = d;
   endtask

   task automatic do_reset;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      step();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst   = 1'b1;
      valid = '0;
      wr    = '0;
      addr  = '0;
      wdata = '0;
      mem1[10'h005] <= 32'hDEADBEEF;
      mem2[10'h005] <= 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
         mem1[10'h010 + 10'(i)] <= 32'hA000_0000 + 32'(i);
         mem2[10'h010 + 10'(i)] <= 32'hA000_0000 + 32'(i);
      end
      mem1[10'h020] <= 32'h0BADF00D;
      mem2[10'h020] <= 32'h0BADF00D;
      mem1[10'h030] <= 32'h0000_3333;
      mem2[10'h030] <= 32'h0000_3333;
      mem1[10'h031] <= 32'h0000_0000;
      mem2[10'h031] <= 32'h0000_0000;
      #1;
      // reset state
      check("rst_en",    64'(en1),   64'd0);
      check("rst_we",    64'(we1),   64'd0);
      check("rst_addr",  64'(a1),    64'd0);
      check("rst_wdata", 64'(wd1),   64'd0);
      check("rst_rsp",   64'(rsp1),  64'd0);
      check("rst_rdy",   64'(rdy1),  64'd0);
      #10 rst = 1'b0;
      step();

      // 1: single read from client 2
      valid = 4'b0100;
      set_cmd(2, 1'b0, 10'h005, 32'h0);
      #1;
      check("t1_rdy", 64'(rdy1), 64'h4);
      step();
      valid = '0;
      check("t1_en",   64'(en1),  64'd1);
      check("t1_we",   64'(we1),  64'd0);
      check("t1_addr", 64'(a1),   64'h005);
      check("t1_rsp_early", 64'(rsp1), 64'd0);
      step();
      check("t1_rsp",  64'(rsp1),  64'h4);
      check("t1_data", 64'(rdat1), 64'hDEADBEEF);
      check("t1_en_off", 64'(en1), 64'd0);
      check("t1_l2_early", 64'(rsp2), 64'd0);
      step();
      check("t1_rsp_off", 64'(rsp1), 64'd0);
      check("t1_l2_rsp",  64'(rsp2), 64'h4);
      check("t1_l2_data", 64'(rdat2), 64'hDEADBEEF);

      // 2: all clients valid, strict rotation from pointer 0
      do_reset();
      for (int c = 0; c < 4; c++) set_cmd(c, 1'b0, 10'h010 + 10'(c), 32'h0);
      valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("t2_rdy", 64'(rdy1), 64'(4'b0001 << (i % 4)));
         step();
         check("t2_en",   64'(en1), 64'd1);
         check("t2_addr", 64'(a1),  64'(10'h010 + 10'(i % 4)));
         if (i >= 1) begin
            check("t2_rsp",  64'(rsp1),  64'(4'b0001 << ((i - 1) % 4)));
            check("t2_data", 64'(rdat1), 64'(32'hA000_0000 + 32'((i - 1) % 4)));
         end
      end
      valid = '0;
      step();
      check("t2_rsp_last", 64'(rsp1), 64'h8);
      check("t2_en_off",   64'(en1),  64'd0);
      step();
      check("t2_rsp_idle", 64'(rsp1), 64'd0);
      step();

      // 3: client 1 write then read of 0x3FF back-to-back
      valid = 4'b0010;
      set_cmd(1, 1'b1, 10'h3FF, 32'h12345678);
      #1;
      check("t3_rdy_w", 64'(rdy1), 64'h2);
      step();
      set_cmd(1, 1'b0, 10'h3FF, 32'h0);
      #1;
      check("t3_rdy_r", 64'(rdy1), 64'h2);
      check("t3_en_w",  64'(en1),  64'd1);
      check("t3_we",    64'(we1),  64'd1);
      check("t3_addr_w", 64'(a1),  64'h3FF);
      check("t3_wdata", 64'(wd1),  64'h12345678);
      step();
      valid = '0;
      check("t3_en_r",  64'(en1),  64'd1);
      check("t3_we_r",  64'(we1),  64'd0);
      check("t3_no_wrsp", 64'(rsp1), 64'd0);
      step();
      check("t3_rsp",  64'(rsp1),  64'h2);
      check("t3_data", 64'(rdat1), 64'h12345678);
      step();
      check("t3_rsp_off", 64'(rsp1), 64'd0);
      step();

      // 4: latency-2 instance, client 0 read
      valid = 4'b0001;
      set_cmd(0, 1'b0, 10'h020, 32'h0);
      #1;
      check("t4_rdy", 64'(rdy2), 64'h1);
      step();
      valid = '0;
      check("t4_rsp_c1", 64'(rsp2), 64'd0);
      step();
      check("t4_rsp_c2", 64'(rsp2), 64'd0);
      check("t4_l1_rsp", 64'(rsp1), 64'h1);
      step();
      check("t4_rsp",  64'(rsp2),  64'h1);
      check("t4_data", 64'(rdat2), 64'h0BADF00D);
      step();
      check("t4_rsp_off", 64'(rsp2), 64'd0);

      // 5: reset with reads from clients 3 and 0 in flight
      valid = 4'b1001;
      set_cmd(3, 1'b0, 10'h030, 32'h0);
      set_cmd(0, 1'b0, 10'h031, 32'h0);
      #1;
      check("t5_rdy3", 64'(rdy1), 64'h8);
      step();
      valid = 4'b0001;
      #1;
      check("t5_rdy0", 64'(rdy1), 64'h1);
      step();
      valid = '0;
      #2 rst = 1'b1;
      #1;
      check("t5_en",    64'(en1),  64'd0);
      check("t5_we",    64'(we1),  64'd0);
      check("t5_addr",  64'(a1),   64'd0);
      check("t5_rsp1",  64'(rsp1), 64'd0);
      check("t5_rsp2",  64'(rsp2), 64'd0);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_quiet1", 64'(rsp1), 64'd0);
         check("t5_quiet2", 64'(rsp2), 64'd0);
      end
      valid = 4'b1001;
      #1;
      check("t5_ptr0", 64'(rdy1), 64'h1);
      valid = '0;

      // 6: client 3 last, then 0 and 3 contend -> 0 first, then 3
      valid = 4'b1000;
      #1;
      check("t6_rdy3a", 64'(rdy1), 64'h8);
      step();
      valid = 4'b1001;
      #1;
      check("t6_rdy0", 64'(rdy1), 64'h1);
      step();
      valid = 4'b1000;
      #1;
      check("t6_addr0", 64'(a1),   64'h031);
      check("t6_rdy3b", 64'(rdy1), 64'h8);
      step();
      valid = '0;
      check("t6_addr3", 64'(a1), 64'h030);
      step();
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
